matrix_bcm: RTL and testbench
=============================

MATRIX_BCM -- requirements
Module: matrix_bcm

Interface
REQ-001 Parameters SHALL be: ROWS (default 8), row count; COLS (default 8), column count; BPC (default 4, range 1..8), bits per colour channel; BASE_HOLD (default 16), cycles per least-significant-plane hold unit.
REQ-002 Local constants SHALL be: N = 3*COLS+ROWS, shift bits per load; AW = clog2(ROWS*COLS), pixel address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_refresh_speed  in  2  hold-unit scale; unit = BASE_HOLD << i_refresh_speed, sampled at each HOLD entry.
REQ-006 o_matrix_clk, o_matrix_latch, o_matrix_mosi  out  1 each  shift clock, output latch strobe, serial data.
REQ-007 o_frame_sync  out  1  one-cycle pulse at the end of every frame.
REQ-008 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  pipelined Wishbone slave controls.
REQ-009 i_wb_addr  in  AW+1  bit AW=0 selects a pixel (index row*COLS+col); bit AW=1 selects the control register.
REQ-010 i_wb_sel  in  4; i_wb_wdata  in  32; o_wb_ack, o_wb_stall  out  1 each; o_wb_rdata  out  32.

Function
REQ-011 Pixel word layout SHALL be: red [BPC-1:0], green [8+BPC-1:8], blue [16+BPC-1:16]; all other bits read 0.
REQ-012 Storage SHALL be two banks of ROWS*COLS pixels; the front bank is scanned and the back bank is the Wishbone target.
REQ-013 Pixel writes SHALL update only the byte lanes enabled by i_wb_sel[2:0] in the back bank.
REQ-014 Pixel reads SHALL return back-bank contents.
REQ-015 Control write with i_wb_sel[0]=1 and wdata[0]=1 SHALL set swap_pending; the request is ignored if swap_pending is already set.
REQ-016 Control read SHALL return {30'b0, front_index, swap_pending}.
REQ-017 o_wb_stall SHALL be constant 0.
REQ-018 o_wb_ack SHALL assert exactly one cycle after each cycle with i_wb_cyc && i_wb_stb; o_wb_rdata is valid in the ack cycle.
REQ-019 Scanner FSM states SHALL be LOAD -> SHIFT -> LATCH -> HOLD, with loop counters row (0..ROWS-1, outer) and plane (0..BPC-1, inner).
REQ-020 LOAD (1 cycle) SHALL build word = {row_onehot[ROWS-1:0], blue_bits[COLS-1:0], green_bits[COLS-1:0], red_bits[COLS-1:0]}, where a colour bit for column c is bit `plane` of that channel of front pixel (row, c).
REQ-021 SHIFT SHALL take 2N cycles, MSB first, per bit: cycle A with mosi=bit and o_matrix_clk=0, then cycle B with o_matrix_clk=1 and mosi held.
REQ-022 LATCH (1 cycle) SHALL drive o_matrix_latch=1 and o_matrix_clk=0.
REQ-023 HOLD SHALL last (1<<plane)*unit cycles with latch=0 and clk=0; on exit it advances plane, and after plane BPC-1 it advances row with wrap to 0.
REQ-024 Frame end (HOLD exit of row ROWS-1, plane BPC-1) SHALL pulse o_frame_sync, and if swap_pending, toggle front_index and clear swap_pending in the same cycle.
REQ-025 A swap write coinciding with frame end SHALL take effect at the following frame end.
REQ-026 A pixel write to the back bank SHALL never alter displayed data mid-frame.

Reset
REQ-027 Reset SHALL take effect on the next clock: o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync, o_wb_ack = 0; o_wb_rdata = 0; front_index=0; swap_pending=0; FSM=LOAD with row=0, plane=0.
REQ-028 Reset SHALL NOT clear pixel storage.
REQ-029 Reset asserted mid-SHIFT or mid-HOLD SHALL abort the transfer with no latch pulse.
REQ-030 A Wishbone request in the reset cycle SHALL not be acked and SHALL have no effect.

Structure
REQ-031 Package matrix_pkg SHALL hold the scanner state enum, pixel field offsets (0/8/16), and the control-register bit indices.
REQ-032 Sub-module matrix_framebuf SHALL implement the two banks with a Wishbone-side port (byte-enable write, read) and a scanner-side read of one full row.

Verification
REQ-033 After reset, with defaults and speed=0, bench SHALL measure a 4032-cycle frame (per row 4*66 + 16*15) and an o_frame_sync period of 4032.
REQ-034 Write pixel (row 2, col 5) = 0x000F0A05, swap, wait 2 frames: row-2 loads SHALL show red col5 = 1,0,1,0 and green = 0,1,0,1 for planes 0..3, blue 0, and row bits = 8'b00000100.
REQ-035 Write with sel=4'b0010 data 0x00FF0000 then read: only the green byte SHALL change; ack exactly 1 cycle after stb.
REQ-036 Two swap writes in one frame: front_index SHALL toggle once at frame end; control read before frame end SHALL return 0x1, after it 0x2.
REQ-037 Speed=3: the plane-3 hold SHALL be 1024 cycles.
REQ-038 Reset asserted at shift bit 10: all outputs SHALL be 0 the next cycle, no latch pulse, and the next load SHALL be row 0 plane 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the BCM LED-matrix driver.
// Scanner state encoding, pixel word field offsets and control-register bit positions.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD
  } scan_state_t;

  localparam int RED_OFS = 0;
  localparam int GRN_OFS = 8;
  localparam int BLU_OFS = 16;

  localparam int CTRL_SWAP_BIT  = 0;
  localparam int CTRL_FRONT_BIT = 1;

endpackage

// File: rtl/matrix_framebuf.sv
// Double-buffered pixel store: byte-lane Wishbone write/read on one bank, full-row read on the other.
// Writes land on the next clock edge; both read paths are combinational and never stall.
module matrix_framebuf
  import matrix_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BPC  = 4,
  parameter int AW   = $clog2(ROWS*COLS),
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        clk,
  input  logic                        wb_bank,
  input  logic                        wb_we,
  input  logic [AW-1:0]               wb_addr,
  input  logic [2:0]                  wb_sel,
  input  logic [31:0]                 wb_wdata,
  output logic [31:0]                 wb_rdata,
  input  logic                        scan_bank,
  input  logic [RW-1:0]               scan_row,
  output logic [COLS-1:0][BPC-1:0]    row_red,
  output logic [COLS-1:0][BPC-1:0]    row_grn,
  output logic [COLS-1:0][BPC-1:0]    row_blu
);

  localparam int NPIX = ROWS * COLS;
  localparam logic [AW:0] NPIX_W = (AW+1)'(NPIX);

  logic [BPC-1:0] red_mem [0:1][0:NPIX-1];
  logic [BPC-1:0] grn_mem [0:1][0:NPIX-1];
  logic [BPC-1:0] blu_mem [0:1][0:NPIX-1];

  logic in_range;
  logic unused_wdata;

  assign in_range     = {1'b0, wb_addr} < NPIX_W;
  assign unused_wdata = ^wb_wdata;

  // No reset: pixel contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wb_we && in_range) begin
      if (wb_sel[0]) red_mem[wb_bank][wb_addr] <= wb_wdata[RED_OFS +: BPC];
      if (wb_sel[1]) grn_mem[wb_bank][wb_addr] <= wb_wdata[GRN_OFS +: BPC];
      if (wb_sel[2]) blu_mem[wb_bank][wb_addr] <= wb_wdata[BLU_OFS +: BPC];
    end
  end

  always_comb begin
    wb_rdata = '0;
    if (in_range) begin
      wb_rdata[RED_OFS +: BPC] = red_mem[wb_bank][wb_addr];
      wb_rdata[GRN_OFS +: BPC] = grn_mem[wb_bank][wb_addr];
      wb_rdata[BLU_OFS +: BPC] = blu_mem[wb_bank][wb_addr];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [AW-1:0] idx;
    assign idx        = AW'(int'(scan_row) * COLS + c);
    assign row_red[c] = red_mem[scan_bank][idx];
    assign row_grn[c] = grn_mem[scan_bank][idx];
    assign row_blu[c] = blu_mem[scan_bank][idx];
  end

endmodule

// File: rtl/matrix_bcm.sv
// Binary-code-modulation scanner for a serial-shift LED matrix with a Wishbone double-buffered frame store.
// Wishbone acks one cycle after each strobe and never stalls; the scanner free-runs LOAD/SHIFT/LATCH/HOLD.
module matrix_bcm
  import matrix_pkg::*;
#(
  parameter int  ROWS      = 8,
  parameter int  COLS      = 8,
  parameter int  BPC       = 4,
  parameter int  BASE_HOLD = 16,
  localparam int N         = 3*COLS + ROWS,
  localparam int AW        = $clog2(ROWS*COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    i_refresh_speed,
  output logic          o_matrix_clk,
  output logic          o_matrix_latch,
  output logic          o_matrix_mosi,
  output logic          o_frame_sync,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW:0]   i_wb_addr,
  input  logic [3:0]    i_wb_sel,
  input  logic [31:0]   i_wb_wdata,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic [31:0]   o_wb_rdata
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CW = $clog2(2*N);

  scan_state_t             state;
  logic [RW-1:0]           row;
  logic [PW-1:0]           plane;
  logic [CW-1:0]           bit_cnt;
  logic [31:0]             hold_cnt;
  logic [31:0]             hold_len_m1;
  logic [4:0]              shamt;
  logic [N-1:0]            shreg;
  logic [N-1:0]            word;
  logic                    front_index;
  logic                    swap_pending;
  logic                    last_slot;
  logic                    frame_end;
  logic                    wb_req;
  logic                    pix_we;
  logic                    swap_req;
  logic [31:0]             fb_rdata;
  logic [31:0]             ctrl_word;
  logic [COLS-1:0][BPC-1:0] row_red;
  logic [COLS-1:0][BPC-1:0] row_grn;
  logic [COLS-1:0][BPC-1:0] row_blu;
  logic                    unused_sel;

  assign o_wb_stall  = 1'b0;
  assign unused_sel  = i_wb_sel[3];
  assign wb_req      = i_wb_cyc && i_wb_stb;
  assign pix_we      = wb_req && i_wb_we && !i_wb_addr[AW] && !reset;
  assign swap_req    = wb_req && i_wb_we && i_wb_addr[AW] && i_wb_sel[0] && i_wb_wdata[0];
  assign last_slot   = (row == RW'(ROWS-1)) && (plane == PW'(BPC-1));
  assign frame_end   = (state == ST_HOLD) && (hold_cnt == '0) && last_slot;
  // Plane weight and speed scale combine into one shift of the base unit.
  assign shamt       = 5'(i_refresh_speed) + 5'(plane);
  assign hold_len_m1 = (32'(BASE_HOLD) << shamt) - 32'd1;

  matrix_framebuf #(.ROWS(ROWS), .COLS(COLS), .BPC(BPC), .AW(AW), .RW(RW)) u_fb (
    .clk       (clk),
    .wb_bank   (~front_index),
    .wb_we     (pix_we),
    .wb_addr   (i_wb_addr[AW-1:0]),
    .wb_sel    (i_wb_sel[2:0]),
    .wb_wdata  (i_wb_wdata),
    .wb_rdata  (fb_rdata),
    .scan_bank (front_index),
    .scan_row  (row),
    .row_red   (row_red),
    .row_grn   (row_grn),
    .row_blu   (row_blu)
  );

  always_comb begin
    word = '0;
    for (int c = 0; c < COLS; c++) begin
      word[c]          = row_red[c][plane];
      word[COLS + c]   = row_grn[c][plane];
      word[2*COLS + c] = row_blu[c][plane];
    end
    for (int r = 0; r < ROWS; r++) word[3*COLS + r] = (RW'(r) == row);
  end

  always_comb begin
    ctrl_word                 = '0;
    ctrl_word[CTRL_SWAP_BIT]  = swap_pending;
    ctrl_word[CTRL_FRONT_BIT] = front_index;
  end

  // Outputs are registered alongside the state so they line up with the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_LOAD;
      row            <= '0;
      plane          <= '0;
      bit_cnt        <= '0;
      hold_cnt       <= '0;
      shreg          <= '0;
      o_matrix_clk   <= 1'b0;
      o_matrix_latch <= 1'b0;
      o_matrix_mosi  <= 1'b0;
      o_frame_sync   <= 1'b0;
      front_index    <= 1'b0;
      swap_pending   <= 1'b0;
    end else begin
      o_frame_sync <= 1'b0;
      if (frame_end && swap_pending) begin
        front_index  <= ~front_index;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      case (state)
        ST_LOAD: begin
          shreg         <= word;
          bit_cnt       <= '0;
          o_matrix_mosi <= word[N-1];
          o_matrix_clk  <= 1'b0;
          state         <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt == CW'(2*N-1)) begin
            o_matrix_clk   <= 1'b0;
            o_matrix_mosi  <= 1'b0;
            o_matrix_latch <= 1'b1;
            state          <= ST_LATCH;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (!bit_cnt[0]) begin
              o_matrix_clk <= 1'b1;
            end else begin
              o_matrix_clk  <= 1'b0;
              shreg         <= shreg << 1;
              o_matrix_mosi <= shreg[N-2];
            end
          end
        end
        ST_LATCH: begin
          o_matrix_latch <= 1'b0;
          hold_cnt       <= hold_len_m1;
          state          <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state        <= ST_LOAD;
            o_frame_sync <= last_slot;
            if (plane == PW'(BPC-1)) begin
              plane <= '0;
              row   <= (row == RW'(ROWS-1)) ? '0 : row + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt - 32'd1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_wb_ack   <= 1'b0;
      o_wb_rdata <= '0;
    end else begin
      o_wb_ack <= wb_req;
      if (wb_req) o_wb_rdata <= i_wb_addr[AW] ? ctrl_word : fb_rdata;
    end
  end

endmodule

// File: tb/tb_matrix_bcm.sv
// Directed bench for matrix_bcm with default parameters (8x8, 4 bpc, base hold 16).
module tb_matrix_bcm;

  localparam int AW = 6;
  localparam logic [AW:0] CTRL_ADDR = 7'h40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    i_refresh_speed = 2'd0;
  logic          o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync;
  logic          i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [AW:0]   i_wb_addr = '0;
  logic [3:0]    i_wb_sel = '0;
  logic [31:0]   i_wb_wdata = '0;
  logic          o_wb_ack, o_wb_stall;
  logic [31:0]   o_wb_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cap_words[$];
  int          cap_bits[$];

  matrix_bcm dut (
    .clk(clk), .reset(reset), .i_refresh_speed(i_refresh_speed),
    .o_matrix_clk(o_matrix_clk), .o_matrix_latch(o_matrix_latch),
    .o_matrix_mosi(o_matrix_mosi), .o_frame_sync(o_frame_sync),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_sel(i_wb_sel), .i_wb_wdata(i_wb_wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_rdata(o_wb_rdata)
  );

  always #5 clk = ~clk;

  // One single-beat transaction; ack1 is the ack seen the cycle after the strobe,
  // ack_other is any ack seen in the strobe cycle or the cycle after ack1.
  task automatic wb_cycle(input logic we, input logic [AW:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, output logic ack1, output logic ack_other,
                          output logic [31:0] rdata);
    @(negedge clk);
    ack_other = o_wb_ack;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_addr = addr; i_wb_sel = sel; i_wb_wdata = data;
    @(negedge clk);
    ack1 = o_wb_ack;
    rdata = o_wb_rdata;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge clk);
    ack_other = ack_other | o_wb_ack;
  endtask

  task automatic wait_sync(input int budget, output bit ok, output int cycles);
    ok = 1'b0; cycles = 0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (o_frame_sync) ok = 1'b1;
    end
  endtask

  task automatic capture(input int n, input int budget, output bit ok, output int cycles);
    logic [31:0] sh;
    int bits;
    sh = '0; bits = 0; cycles = 0; ok = 1'b0;
    cap_words.delete(); cap_bits.delete();
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (o_matrix_clk) begin sh = {sh[30:0], o_matrix_mosi}; bits++; end
      if (o_matrix_latch) begin cap_words.push_back(sh); cap_bits.push_back(bits); bits = 0; end
      if (cap_words.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic a1, ao; logic [31:0] rd;
    // A swap request presented during reset must be ignored.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
    i_wb_addr = CTRL_ADDR; i_wb_sel = 4'b0001; i_wb_wdata = 32'h1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync, o_wb_ack, o_wb_stall} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync, o_wb_ack, o_wb_stall});
    end
    n_cmp++;
    if (o_wb_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h expected 00000000", o_wb_rdata);
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    reset = 1'b0;
    wb_cycle(1'b0, CTRL_ADDR, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h expected 00000000", rd); end
  endtask

  task automatic test_frame_timing;
    bit ok; int cyc; int bad_bits; int bad_rows; logic [31:0] w; logic [7:0] exp_row;
    wait_sync(5000, ok, cyc);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL first_sync: got timeout after %0d expected pulse", cyc); end
    capture(32, 5000, ok, cyc);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL frame_latches: got %0d expected 32", cap_words.size()); end
    bad_bits = 0; bad_rows = 0;
    for (int k = 0; k < cap_words.size(); k++) begin
      w = cap_words[k];
      exp_row = 8'h01 << (k / 4);
      if (cap_bits[k] != 32) bad_bits++;
      if (w[31:24] !== exp_row) bad_rows++;
    end
    n_cmp++;
    if (bad_bits != 0) begin n_bad++; $display("FAIL bits_per_load: got %0d bad loads expected 0", bad_bits); end
    n_cmp++;
    if (bad_rows != 0) begin n_bad++; $display("FAIL row_select: got %0d bad loads expected 0", bad_rows); end
    wait_sync(5000, ok, cyc);
    for (int f = 0; f < 2; f++) begin
      wait_sync(5000, ok, cyc);
      n_cmp++;
      if (!ok || cyc != 4032) begin
        n_bad++; $display("FAIL frame_period%0d: got %0d expected 4032", f, cyc);
      end
    end
  endtask

  task automatic test_wb_bytes;
    logic a1, ao; logic [31:0] rd;
    wb_cycle(1'b1, 7'd9, 4'b0111, 32'h00030201, a1, ao, rd);
    n_cmp++;
    if (a1 !== 1'b1 || ao !== 1'b0) begin
      n_bad++; $display("FAIL write_ack: got ack1=%b other=%b expected ack1=1 other=0", a1, ao);
    end
    wb_cycle(1'b0, 7'd9, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h00030201 || a1 !== 1'b1 || ao !== 1'b0) begin
      n_bad++; $display("FAIL pixel_read: got %h ack1=%b other=%b expected 00030201 1 0", rd, a1, ao);
    end
    wb_cycle(1'b1, 7'd9, 4'b0010, 32'h00FF0000, a1, ao, rd);
    wb_cycle(1'b0, 7'd9, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h00030001) begin n_bad++; $display("FAIL green_lane_only: got %h expected 00030001", rd); end
    wb_cycle(1'b1, 7'd9, 4'b1111, 32'hFFFFFFFF, a1, ao, rd);
    wb_cycle(1'b0, 7'd9, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h000F0F0F) begin n_bad++; $display("FAIL field_mask: got %h expected 000F0F0F", rd); end
    n_cmp++;
    if (o_wb_stall !== 1'b0) begin n_bad++; $display("FAIL stall: got %b expected 0", o_wb_stall); end
  endtask

  task automatic test_double_swap;
    logic a1, ao; logic [31:0] rd; bit ok; int cyc;
    wait_sync(5000, ok, cyc);
    wb_cycle(1'b1, CTRL_ADDR, 4'b0001, 32'h1, a1, ao, rd);
    wb_cycle(1'b1, CTRL_ADDR, 4'b0001, 32'h1, a1, ao, rd);
    wb_cycle(1'b0, CTRL_ADDR, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_bad++; $display("FAIL ctrl_pending: got %h expected 00000001", rd); end
    wait_sync(5000, ok, cyc);
    wb_cycle(1'b0, CTRL_ADDR, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_bad++; $display("FAIL ctrl_swapped: got %h expected 00000002", rd); end
    wait_sync(5000, ok, cyc);
    wb_cycle(1'b0, CTRL_ADDR, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_bad++; $display("FAIL single_toggle: got %h expected 00000002", rd); end
  endtask

  task automatic test_pixel_scan;
    logic a1, ao; logic [31:0] rd; bit ok; int cyc; logic [31:0] w;
    bit red_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit grn_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    // Pixel (2,5) is index 21; blue lane is cleared first, then left untouched.
    wb_cycle(1'b1, 7'd21, 4'b0111, 32'h0, a1, ao, rd);
    wb_cycle(1'b1, 7'd21, 4'b0011, 32'h000F0A05, a1, ao, rd);
    wb_cycle(1'b0, 7'd21, 4'b1111, 32'h0, a1, ao, rd);
    n_cmp++;
    if (rd !== 32'h00000A05) begin n_bad++; $display("FAIL pixel21_read: got %h expected 00000A05", rd); end
    wb_cycle(1'b1, CTRL_ADDR, 4'b0001, 32'h1, a1, ao, rd);
    wait_sync(5000, ok, cyc);
    capture(32, 5000, ok, cyc);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL scan_capture: got %0d loads expected 32", cap_words.size()); end
    for (int p = 0; p < 4; p++) begin
      w = (cap_words.size() > 8 + p) ? cap_words[8 + p] : 32'hFFFFFFFF;
      n_cmp++;
      if (w[5] !== red_exp[p] || w[13] !== grn_exp[p] || w[21] !== 1'b0 || w[31:24] !== 8'b00000100) begin
        n_bad++;
        $display("FAIL row2_plane%0d: got r=%b g=%b b=%b row=%b expected r=%b g=%b b=0 row=00000100",
                 p, w[5], w[13], w[21], w[31:24], red_exp[p], grn_exp[p]);
      end
    end
  endtask

  task automatic test_speed;
    bit ok; int cyc; int latches; int cnt; int gap1; int gap4; bit counting;
    i_refresh_speed = 2'd3;
    wait_sync(20000, ok, cyc);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL speed_sync: got timeout after %0d expected pulse", cyc); end
    latches = 0; cnt = 0; gap1 = -1; gap4 = -1; counting = 1'b0; cyc = 0;
    while (gap4 < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (counting) cnt++;
      if (counting && o_matrix_clk) begin
        if (latches == 1) gap1 = cnt; else gap4 = cnt;
        counting = 1'b0;
      end
      if (o_matrix_latch) begin
        latches++;
        if (latches == 1 || latches == 4) begin counting = 1'b1; cnt = 0; end
      end
    end
    // Latch-to-first-shift-clock spans hold + LOAD + one data-setup cycle + 1.
    n_cmp++;
    if (gap1 != 131) begin n_bad++; $display("FAIL speed3_plane0: got %0d expected 131", gap1); end
    n_cmp++;
    if (gap4 != 1027) begin n_bad++; $display("FAIL speed3_plane3: got %0d expected 1027", gap4); end
    i_refresh_speed = 2'd0;
  endtask

  task automatic test_reset_mid_shift;
    bit ok; int cyc; int pulses; int gap; logic [31:0] w;
    ok = 1'b0; cyc = 0; pulses = 0;
    while (!ok && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (o_matrix_latch) ok = 1'b1;
    end
    while (pulses < 10 && cyc < 3200) begin
      @(negedge clk); cyc++;
      if (o_matrix_clk) pulses++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync, o_wb_ack} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_outputs: got %b expected 00000",
               {o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_frame_sync, o_wb_ack});
    end
    capture(1, 200, ok, cyc);
    w = ok ? cap_words[0] : 32'h0;
    n_cmp++;
    if (!ok || cyc != 65 || cap_bits[0] != 32) begin
      n_bad++; $display("FAIL abort_first_latch: got cycle %0d bits %0d expected cycle 65 bits 32",
                        cyc, ok ? cap_bits[0] : -1);
    end
    n_cmp++;
    if (w[31:24] !== 8'b00000001) begin n_bad++; $display("FAIL abort_row: got %b expected 00000001", w[31:24]); end
    gap = 0; ok = 1'b0;
    while (!ok && gap < 200) begin
      @(negedge clk); gap++;
      if (o_matrix_clk) ok = 1'b1;
    end
    n_cmp++;
    if (gap != 19) begin n_bad++; $display("FAIL abort_plane0_hold: got %0d expected 19", gap); end
  endtask

  initial begin
    test_reset;
    test_frame_timing;
    test_wb_bytes;
    test_double_swap;
    test_pixel_scan;
    test_speed;
    test_reset_mid_shift;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
